axi_dma_copy_master: RTL and testbench
======================================

// Module: axi_dma_copy_master
// PURPOSE
//  Synthesizable AXI4 burst initiator that copies len_beats words from src_addr to dst_addr.
//  Sits as a NoC master port (drop-in for the DMA master model), e.g. SRAM->MRAM copies.
//  Store-and-forward per burst: AR -> R beats into local FIFO -> AW -> W beats from FIFO -> B.
// PARAMETERS
//  AXI_ID_WIDTH    4   ID width; all AR/AW carry ID = DMA_ID
//  AXI_ADDR_WIDTH  32  byte address width
//  AXI_DATA_WIDTH  64  beat width; beat size BYTES = AXI_DATA_WIDTH/8
//  MAX_BURST       16  max beats per burst (equals MRAM slave BURST_LEN); FIFO depth
//  DMA_ID          1   constant transaction ID
// PORTS
//  clk        in  1   clock
//  rst        in  1   synchronous active-high reset
//  start      in  1   1-cycle request; sampled only in IDLE
//  src_addr   in  AW  source byte address, BYTES-aligned
//  dst_addr   in  AW  destination byte address, BYTES-aligned
//  len_beats  in  16  total beats to copy (0 allowed)
//  busy       out 1   high from accepted start until done
//  done       out 1   1-cycle pulse at end of job
//  err        out 1   sticky job status, valid with done; cleared by next accepted start
//  AW ch: awid out ID, awaddr out AW, awlen out 8, awvalid out 1, awready in 1
//  W  ch: wdata out DW, wlast out 1, wvalid out 1, wready in 1
//  B  ch: bid in ID, bresp in 2, bvalid in 1, bready out 1
//  AR ch: arid out ID, araddr out AW, arlen out 8, arvalid out 1, arready in 1
//  R  ch: rid in ID, rdata in DW, rresp in 2, rvalid in 1, rlast in 1, rready out 1
// BEHAVIOUR
//  Reset: all valid/ready outputs 0, busy=0, done=0, err=0, addr/len/wdata regs 0, FSM=IDLE, FIFO empty.
//  Reset mid-job aborts immediately; no outstanding-handshake completion (fabric is reset too).
//  FSM: IDLE -> AR -> R -> AW -> W -> B -> (AR | FIN); FIN -> IDLE.
//  IDLE: on start: misaligned src/dst (low log2(BYTES) bits !=0) -> FIN with err=1, no bus traffic;
//        len_beats==0 -> FIN, err=0; else latch src/dst/remaining, busy=1, -> AR.
//  chunk = min(remaining, MAX_BURST); arlen=awlen=chunk-1. 4KB crossing not split (caller's duty).
//  AR: arvalid held with stable araddr/arlen until arready; -> R.
//  R: rready=1 while FIFO not full; push rdata; rresp!=OKAY sets err; rlast or chunk-th beat -> AW.
//     rid != DMA_ID sets err (beat still consumed).
//  AW: awvalid held until awready; -> W. W starts only after AW handshake.
//  W: wvalid=!fifo_empty, wdata=FIFO head, wlast on chunk-th beat; pop on wvalid&wready; after last -> B.
//  B: bready=1; on bvalid: bresp!=OKAY or bid mismatch sets err; src+=chunk*BYTES, dst+=chunk*BYTES,
//     remaining-=chunk; err or remaining==0 -> FIN else -> AR.
//  FIN: done=1 for exactly one cycle, busy=0 next cycle, -> IDLE. start ignored while busy/FIN.
//  Error: current burst always completes (AXI requires it); no further bursts issued.
//  Address arithmetic wraps modulo 2^AXI_ADDR_WIDTH; no overflow detection.
//  Throughput: 1 beat/cycle on R and W when slave never stalls; FIFO never over/underflows by design.
//  Simultaneous rvalid & FIFO full cannot occur (FIFO depth == MAX_BURST, drained before next AR).
// STRUCTURE
//  Package soc_axi_pkg: resp_e (OKAY=2'b00, EXOKAY, SLVERR, DECERR), dma_state_e enum, BYTES helper.
//  Sub-module axi_dma_beat_fifo: sync FIFO, DEPTH=MAX_BURST, WIDTH=AXI_DATA_WIDTH, full/empty/count.
//  Top holds FSM, address/length counters, beat counter, channel drivers.
// TESTING
//  1 len=16 src=0x1000 dst=0x8000 -> one AR/AW awlen=15, 16 beats, data matches, done, err=0.
//  2 len=37 -> bursts 16,16,5 at src +0x0,+0x80,+0x100; dst likewise; done once after 3rd B.
//  3 len=0, start -> no AR/AW, done pulses 1 cycle after start, err=0.
//  4 slave stalls randomly on arready/rready/awready/wready -> valids held stable, copy exact.
//  5 bresp=SLVERR on burst 1 of len=40 -> no 2nd AR, done with err=1; next start clears err.
//  6 src=0x1004 -> done next cycle, err=1, no bus traffic; rst asserted mid-W -> all outputs reset values.

Source files
------------

// File: rtl/soc_axi_pkg.sv
// Shared AXI response codes, DMA copy-engine state encoding and beat-size helper.
package soc_axi_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B,
        S_FIN
    } dma_state_e;

    // Bytes carried by one data beat of the given bus width.
    function automatic int unsigned beat_bytes(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/axi_dma_beat_fifo.sv
// Synchronous beat FIFO holding one read burst until it is replayed on the write channel.
module axi_dma_beat_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/axi_dma_copy_master.sv
// AXI4 store-and-forward copy master: each burst is read into a local FIFO, then written out.
// Handshakes: a transfer happens on a rising edge where valid && ready; once a valid is raised
// it and its payload stay stable until that edge, and no valid ever waits on its ready.
module axi_dma_copy_master
    import soc_axi_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int MAX_BURST      = 16,
    parameter int DMA_ID         = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [AXI_ADDR_WIDTH-1:0]         src_addr,
    input  logic [AXI_ADDR_WIDTH-1:0]         dst_addr,
    input  logic [15:0]                       len_beats,
    output logic                              busy,
    output logic                              done,
    output logic                              err,
    output logic [AXI_ID_WIDTH-1:0]           awid,
    output logic [AXI_ADDR_WIDTH-1:0]         awaddr,
    output logic [7:0]                        awlen,
    output logic                              awvalid,
    input  logic                              awready,
    output logic [AXI_DATA_WIDTH-1:0]         wdata,
    output logic                              wlast,
    output logic                              wvalid,
    input  logic                              wready,
    input  logic [AXI_ID_WIDTH-1:0]           bid,
    input  logic [1:0]                        bresp,
    input  logic                              bvalid,
    output logic                              bready,
    output logic [AXI_ID_WIDTH-1:0]           arid,
    output logic [AXI_ADDR_WIDTH-1:0]         araddr,
    output logic [7:0]                        arlen,
    output logic                              arvalid,
    input  logic                              arready,
    input  logic [AXI_ID_WIDTH-1:0]           rid,
    input  logic [AXI_DATA_WIDTH-1:0]         rdata,
    input  logic [1:0]                        rresp,
    input  logic                              rvalid,
    input  logic                              rlast,
    output logic                              rready,
    output dma_state_e                        dbg_state,
    output logic [$clog2(MAX_BURST+1)-1:0]    dbg_fifo_count
);

    localparam int unsigned BYTES = beat_bytes(AXI_DATA_WIDTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = AXI_ADDR_WIDTH'(BYTES - 1);

    dma_state_e                state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] src_q, dst_q, step;
    logic [15:0]               rem_q, rem_after;
    logic [7:0]                len_q;   // beats-1 of the burst in flight
    logic [7:0]                beat_q;  // beat index within the burst, for R then W
    logic                      err_q;
    logic                      misaligned, r_last_beat, b_bad;
    logic                      fifo_full, fifo_empty;
    logic [AXI_DATA_WIDTH-1:0] fifo_head;

    // Burst length (as AXI len, beats-1) for a non-zero remaining count.
    function automatic logic [7:0] chunk_len(input logic [15:0] rem);
        if (rem > 16'(MAX_BURST)) return 8'(MAX_BURST - 1);
        return 8'(rem - 16'd1);
    endfunction

    assign misaligned  = ((src_addr & ALIGN_MASK) != '0) || ((dst_addr & ALIGN_MASK) != '0);
    assign r_last_beat = rlast || (beat_q == len_q);
    assign b_bad       = (resp_e'(bresp) != OKAY) || (bid != AXI_ID_WIDTH'(DMA_ID));
    assign step        = AXI_ADDR_WIDTH'((32'(len_q) + 32'd1) * 32'(BYTES));
    assign rem_after   = rem_q - (16'(len_q) + 16'd1);

    axi_dma_beat_fifo #(
        .DEPTH (MAX_BURST),
        .WIDTH (AXI_DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rvalid && rready),
        .push_data (rdata),
        .pop       (wvalid && wready),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (dbg_fifo_count)
    );

    // Next-state and channel valid/ready generation.
    always_comb begin
        state_d = state_q;
        arvalid = 1'b0;
        rready  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (misaligned || (len_beats == 16'd0)) state_d = S_FIN;
                    else                                    state_d = S_AR;
                end
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) state_d = S_R;
            end
            S_R: begin
                rready = !fifo_full;
                if (rvalid && rready && r_last_beat) state_d = S_AW;
            end
            S_AW: begin
                awvalid = 1'b1;
                if (awready) state_d = S_W;
            end
            S_W: begin
                wvalid = !fifo_empty;
                if (wvalid && wready && (beat_q == len_q)) state_d = S_B;
            end
            S_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    if (err_q || b_bad || (rem_after == 16'd0)) state_d = S_FIN;
                    else                                        state_d = S_AR;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register plus job address/length bookkeeping and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        err_q <= misaligned;
                        if (!misaligned && (len_beats != 16'd0)) begin
                            src_q  <= src_addr;
                            dst_q  <= dst_addr;
                            rem_q  <= len_beats;
                            len_q  <= chunk_len(len_beats);
                            beat_q <= '0;
                        end
                    end
                end
                S_R: begin
                    if (rvalid && rready) begin
                        if ((resp_e'(rresp) != OKAY) || (rid != AXI_ID_WIDTH'(DMA_ID))) err_q <= 1'b1;
                        beat_q <= r_last_beat ? '0 : beat_q + 8'd1;
                    end
                end
                S_W: begin
                    if (wvalid && wready) beat_q <= (beat_q == len_q) ? '0 : beat_q + 8'd1;
                end
                S_B: begin
                    if (bvalid) begin
                        if (b_bad) err_q <= 1'b1;
                        src_q <= src_q + step;
                        dst_q <= dst_q + step;
                        rem_q <= rem_after;
                        if (rem_after != 16'd0) len_q <= chunk_len(rem_after);
                    end
                end
                default: ;
            endcase
        end
    end

    assign arid      = AXI_ID_WIDTH'(DMA_ID);
    assign awid      = AXI_ID_WIDTH'(DMA_ID);
    assign araddr    = src_q;
    assign awaddr    = dst_q;
    assign arlen     = len_q;
    assign awlen     = len_q;
    assign wdata     = wvalid ? fifo_head : '0;
    assign wlast     = wvalid && (beat_q == len_q);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN);
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_axi_dma_copy_master.sv
`timescale 1ns/1ps
module tb_axi_dma_copy_master;
    import soc_axi_pkg::*;

    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int DID = 1;

    logic           clk, rst, start;
    logic [AW-1:0]  src_addr, dst_addr;
    logic [15:0]    len_beats;
    logic           busy, done, err;
    logic [IDW-1:0] awid, arid, bid, rid;
    logic [AW-1:0]  awaddr, araddr;
    logic [7:0]     awlen, arlen;
    logic           awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic           arvalid, arready, rvalid, rlast, rready;
    logic [DW-1:0]  wdata, rdata;
    logic [1:0]     bresp, rresp;
    dma_state_e     dbg_state;
    logic [4:0]     dbg_fifo_count;

    int vec_cnt = 0;
    int err_cnt = 0;

    int          stall_pct = 0;
    int          b_err_burst = -1;
    int          b_idx = 0;
    logic [31:0] salt = 32'h0;
    logic [43:0] obs_ar_q[$];
    logic [43:0] obs_aw_q[$];
    logic [63:0] wmem [logic [31:0]];

    axi_dma_copy_master dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len_beats(len_beats), .busy(busy), .done(done), .err(err),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready),
        .dbg_state(dbg_state), .dbg_fifo_count(dbg_fifo_count)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Source memory contents as a function of byte address.
    function automatic logic [63:0] pat(input logic [31:0] a);
        return {a ^ salt, (a * 32'h9E37_79B1) + salt};
    endfunction

    // Read slave: accepts AR, returns arlen+1 beats with random gaps.
    initial begin : rd_slave
        logic        active, hold, prev_v;
        logic [31:0] prev_a, addr;
        logic [7:0]  prev_l;
        int          left;
        active = 0; hold = 0; prev_v = 0; prev_a = 0; prev_l = 0; addr = 0; left = 0;
        arready = 0; rvalid = 0; rdata = '0; rlast = 0; rresp = 2'b00; rid = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0; hold = 0; prev_v = 0; arready = 0; rvalid = 0; rlast = 0;
            end else if (!active) begin
                rvalid = 0; rlast = 0;
                if (prev_v) begin
                    check("ar_valid_held", arvalid, 1'b1);
                    check("ar_addr_held", araddr, prev_a);
                    check("ar_len_held", arlen, prev_l);
                end
                arready = ($urandom_range(99) >= stall_pct);
                if (arvalid && arready) begin
                    obs_ar_q.push_back({arid, araddr, arlen});
                    active = 1; hold = 0; prev_v = 0;
                    addr = araddr; left = int'(arlen) + 1;
                end else begin
                    prev_v = arvalid; prev_a = araddr; prev_l = arlen;
                end
            end else begin
                arready = 0;
                if (!hold) rvalid = ($urandom_range(99) >= stall_pct);
                if (rvalid) begin
                    rdata = pat(addr); rlast = (left == 1); rresp = OKAY; rid = IDW'(DID);
                end else begin
                    rlast = 0;
                end
                hold = rvalid && !rready;
                if (rvalid && rready) begin
                    addr += 32'd8; left--;
                    if (left == 0) active = 0;
                end
            end
        end
    end

    // Write slave: accepts AW, stores W beats, answers B (SLVERR on the selected burst).
    initial begin : wr_slave
        logic        aw_acc, b_pend, prev_v;
        logic [31:0] prev_a, waddr;
        logic [7:0]  prev_l;
        int          wleft;
        aw_acc = 0; b_pend = 0; prev_v = 0; prev_a = 0; prev_l = 0; waddr = 0; wleft = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 2'b00; bid = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_acc = 0; b_pend = 0; prev_v = 0; awready = 0; wready = 0; bvalid = 0;
            end else if (!aw_acc && !b_pend) begin
                wready = 0; bvalid = 0;
                if (wvalid) check("w_before_aw", wvalid, 1'b0);
                if (prev_v) begin
                    check("aw_valid_held", awvalid, 1'b1);
                    check("aw_addr_held", awaddr, prev_a);
                    check("aw_len_held", awlen, prev_l);
                end
                awready = ($urandom_range(99) >= stall_pct);
                if (awvalid && awready) begin
                    obs_aw_q.push_back({awid, awaddr, awlen});
                    aw_acc = 1; prev_v = 0; waddr = awaddr; wleft = int'(awlen) + 1;
                end else begin
                    prev_v = awvalid; prev_a = awaddr; prev_l = awlen;
                end
            end else if (aw_acc) begin
                awready = 0;
                wready = ($urandom_range(99) >= stall_pct);
                if (wvalid && wready) begin
                    wmem[waddr] = wdata;
                    check("wlast", wlast, (wleft == 1));
                    waddr += 32'd8; wleft--;
                    if (wleft == 0) begin aw_acc = 0; b_pend = 1; end
                end
            end else begin
                wready = 0;
                if (!bvalid) bvalid = ($urandom_range(99) >= stall_pct);
                bresp = (b_idx == b_err_burst) ? SLVERR : OKAY;
                bid   = IDW'(DID);
                if (bvalid && bready) begin b_idx++; b_pend = 0; end
            end
        end
    end

    task automatic reset_checks(input string tag);
        check({tag, ":arvalid"}, arvalid, 0);
        check({tag, ":awvalid"}, awvalid, 0);
        check({tag, ":wvalid"}, wvalid, 0);
        check({tag, ":rready"}, rready, 0);
        check({tag, ":bready"}, bready, 0);
        check({tag, ":busy"}, busy, 0);
        check({tag, ":done"}, done, 0);
        check({tag, ":err"}, err, 0);
        check({tag, ":araddr"}, araddr, 0);
        check({tag, ":awaddr"}, awaddr, 0);
        check({tag, ":arlen"}, arlen, 0);
        check({tag, ":awlen"}, awlen, 0);
        check({tag, ":wdata"}, wdata, 0);
        check({tag, ":wlast"}, wlast, 0);
        check({tag, ":state"}, dbg_state, S_IDLE);
        check({tag, ":fifo_count"}, dbg_fifo_count, 0);
    endtask

    // One copy job: reference bursts and destination image come from the chunking rule.
    task automatic run_job(input string name, input logic [31:0] src, input logic [31:0] dst,
                           input int len, input int err_burst, input int stall, input bit poke);
        logic [43:0] exp_ar_q[$];
        logic [43:0] exp_aw_q[$];
        logic [31:0] exp_wa_q[$];
        logic [63:0] exp_wd_q[$];
        logic [31:0] s, d;
        logic [63:0] got;
        int          rem, c, k, cyc, limit;
        bit          mis, exp_err, quick;
        salt = $urandom();
        stall_pct = stall; b_err_burst = err_burst; b_idx = 0;
        obs_ar_q.delete(); obs_aw_q.delete(); wmem.delete();
        mis = (src % 8 != 0) || (dst % 8 != 0);
        quick = mis || (len == 0);
        exp_err = mis;
        s = src; d = dst; rem = mis ? 0 : len; k = 0;
        while (rem > 0) begin
            c = (rem > 16) ? 16 : rem;
            exp_ar_q.push_back({4'(DID), s, 8'(c - 1)});
            exp_aw_q.push_back({4'(DID), d, 8'(c - 1)});
            for (int j = 0; j < c; j++) begin
                exp_wa_q.push_back(d + 32'(j * 8));
                exp_wd_q.push_back(pat(s + 32'(j * 8)));
            end
            if (k == err_burst) begin exp_err = 1; break; end
            s += 32'(c * 8); d += 32'(c * 8); rem -= c; k++;
        end

        @(negedge clk);
        src_addr = src; dst_addr = dst; len_beats = 16'(len); start = 1;
        @(negedge clk);
        start = 0; cyc = 1;
        if (!quick) begin
            check({name, ":busy"}, busy, 1);
            check({name, ":err_cleared"}, err, 0);
        end
        limit = 400 + len * 40;
        while (!done && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 6) begin start = 1; src_addr = 32'h0; len_beats = 16'd3; end
            if (poke && cyc == 7) start = 0;
        end
        start = 0;
        check({name, ":done"}, done, 1);
        if (quick) check({name, ":done_latency"}, cyc, 1);
        check({name, ":err"}, err, exp_err);
        @(negedge clk);
        check({name, ":done_pulse"}, done, 0);
        check({name, ":busy_after"}, busy, 0);

        check({name, ":ar_count"}, obs_ar_q.size(), exp_ar_q.size());
        check({name, ":aw_count"}, obs_aw_q.size(), exp_aw_q.size());
        for (int i = 0; i < exp_ar_q.size() && i < obs_ar_q.size(); i++)
            check({name, ":ar"}, obs_ar_q[i], exp_ar_q[i]);
        for (int i = 0; i < exp_aw_q.size() && i < obs_aw_q.size(); i++)
            check({name, ":aw"}, obs_aw_q[i], exp_aw_q[i]);
        check({name, ":words_written"}, wmem.num(), exp_wa_q.size());
        for (int i = 0; i < exp_wa_q.size(); i++) begin
            got = wmem.exists(exp_wa_q[i]) ? wmem[exp_wa_q[i]] : 'x;
            check({name, ":wdata"}, got, exp_wd_q[i]);
        end
    endtask

    // Directed sequence.
    initial begin : main
        int          len, eb;
        int          cyc;
        logic [31:0] src, dst;
        rst = 1; start = 0; src_addr = '0; dst_addr = '0; len_beats = '0;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        rst = 0;
        @(negedge clk);

        run_job("single16", 32'h0000_1000, 32'h0000_8000, 16, -1, 0, 0);
        run_job("len37", 32'h0000_2000, 32'h0000_9000, 37, -1, 0, 0);
        run_job("len0", 32'h0000_3000, 32'h0000_A000, 0, -1, 0, 0);

        for (int i = 0; i < 5; i++) begin
            len = $urandom_range(20, 60);
            src = 32'($urandom_range(0, 32'h000F_FFFF)) << 3;
            dst = 32'($urandom_range(0, 32'h000F_FFFF)) << 3;
            eb  = ($urandom_range(3) == 0) ? $urandom_range(0, 3) : -1;
            run_job("random_stall", src, dst, len, eb, 40, 1);
        end

        run_job("bresp_err", 32'h0000_4000, 32'h0000_C000, 40, 0, 20, 0);
        run_job("err_cleared", 32'h0000_5000, 32'h0000_D000, 5, -1, 20, 0);
        run_job("misaligned_src", 32'h0000_1004, 32'h0000_8000, 8, -1, 0, 0);
        run_job("misaligned_dst", 32'h0000_1000, 32'h0000_8002, 8, -1, 0, 0);
        run_job("addr_wrap", 32'hFFFF_FFC0, 32'hFFFF_FF80, 20, -1, 10, 0);

        // Reset while a write burst is in progress.
        salt = $urandom(); stall_pct = 20; b_err_burst = -1; b_idx = 0;
        obs_ar_q.delete(); obs_aw_q.delete(); wmem.delete();
        @(negedge clk);
        src_addr = 32'h0000_6000; dst_addr = 32'h0000_E000; len_beats = 16'd48; start = 1;
        @(negedge clk);
        start = 0; cyc = 0;
        while (!wvalid && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid_w:wvalid_seen", wvalid, 1);
        rst = 1;
        @(negedge clk);
        reset_checks("rst_mid_w");
        rst = 0;
        @(negedge clk);
        run_job("after_reset", 32'h0000_7000, 32'h0000_F000, 18, -1, 30, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
